hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Sequential successor to the combinational hazard unit. Sits in the decode stage of the 5-stage RV32 pipeline, classifies load-use and branch-operand hazards, then drives multi-cycle stalls from a down-counter rather than re-detecting every cycle. Also sequences multi-cycle mispredict flushes and freezes the front end while a multi-cycle EX unit (mul/div) is busy. Stall lengths per hazard class and flush length are parameters.

## Interface
- REG_ADDR_W, 5, register index width
- LOAD_USE_STALL, 1, stall cycles for a load followed by a dependent non-branch
- BRANCH_LOAD_STALL, 2, stall cycles for a load followed by a dependent branch
- BRANCH_ALU_STALL, 1, stall cycles for an ALU write followed by a dependent branch
- FLUSH_CYCLES, 1, cycles `flush` is held after a mispredict (>=1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_attempt_branch  in  1  ID instruction is a conditional branch
- id_branch_taken  in  1  resolved branch outcome in ID
- id_predict_taken  in  1  prediction that accompanied the ID instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source registers
- ex_reg_write  in  1  EX instruction writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  REG_ADDR_W  EX destination
- ex_busy  in  1  multi-cycle EX unit not finished
- stall  out  1  hold PC and IF/ID
- bubble  out  1  zero control signals into ID/EX
- flush  out  1  squash IF/ID and redirect PC
- stall_cause  out  2  hazard_pkg::stall_cause_t of the current stall
- perf_stall_cycles, perf_flush_events  out  32  counters (macro only)

## Operation
- Match = ex_rd != 0 and (ex_rd == id_rs1 or ex_rd == id_rs2), qualified by id_valid.
- Class priority: BR_LOAD (ex_mem_read and id_attempt_branch) > LOAD_USE (ex_mem_read) > BR_ALU (id_attempt_branch and ex_reg_write) > NONE. N = matching parameter.
- States IDLE, STALL, FLUSH; remaining-cycle counter cnt, width clog2(max parameter + 1).
- IDLE, hazard found: stall=1, bubble=1, stall_cause=class this cycle; if N>1 load cnt=N-1, latch cause, go STALL; if N==1 stay IDLE. Mispredict ignored (branch unresolved).
- IDLE, no hazard, id_valid and id_attempt_branch and id_branch_taken != id_predict_taken: flush=1, bubble=1; if FLUSH_CYCLES>1 load cnt=FLUSH_CYCLES-1, go FLUSH.
- STALL: stall=1, bubble=1, latched cause; detection and mispredict suppressed; cnt decrements; cnt==1 -> IDLE next.
- FLUSH: flush=1, bubble=1, stall=0; detection suppressed; cnt==1 -> IDLE next.
- ex_busy=1 (any state): stall=1, bubble=0, stall_cause=BUSY, flush=0, state and cnt frozen; hazard classification deferred until ex_busy drops.
- Outputs combinational from state, cnt, inputs; stall and flush never both 1.
- Reset: IDLE, cnt=0, latched cause NONE, counters 0; with inputs low all outputs 0. Reset mid-stall/flush aborts immediately.

## Timing
- Detection-to-stall latency 0 cycles; total stall = exactly N consecutive cycles absent ex_busy.
- Flush asserted exactly FLUSH_CYCLES consecutive cycles starting in the resolving cycle.
- ex_busy extends any in-progress sequence by its high cycles; no cycle lost or gained.
- Back-to-back: new hazard detectable in first IDLE cycle after STALL/FLUSH.

## Configuration
- HAZARD_PERF_EN defined: perf_stall_cycles increments each cycle stall=1; perf_flush_events increments on each IDLE->flush entry (once per mispredict); both saturate at 2^32-1, reset to 0.
- Undefined: counter registers absent, both ports tied to 0.

## Structure
- hazard_pkg: stall_cause_t {NONE, LOAD_USE, BRANCH, BUSY}, state enum, default stall-length constants.
- Sub-module hazard_classify: combinational match and class priority; hazard_ctrl owns FSM, counter, perf logic.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs2=5, non-branch -> stall/bubble 1 cycle, cause LOAD_USE, then 0.
- Same with id_attempt_branch=1, BRANCH_LOAD_STALL=3 -> stall exactly 3 cycles, mispredict ignored throughout.
- ex_rd=0 with ex_mem_read=1, id_rs1=0 -> no stall.
- Mispredict (taken=1, predict=0), FLUSH_CYCLES=2 -> flush 2 cycles, stall 0, perf_flush_events +1.
- ex_busy high 4 cycles mid 2-cycle branch stall -> stall 6 cycles, bubble 0 during busy.
- rst_n low in STALL cycle 1 -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the decode-stage hazard controller.
// Optional build macro: HAZARD_PERF_EN enables the stall/flush performance counters.
package hazard_pkg;

  // Reason reported alongside an asserted stall.
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    LOAD_USE = 2'd1,
    BRANCH   = 2'd2,
    BUSY     = 2'd3
  } stall_cause_t;

  // Controller sequencing state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Hazard class found in the current cycle, listed in priority order.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_BR_LOAD  = 2'd1,
    HZ_LOAD_USE = 2'd2,
    HZ_BR_ALU   = 2'd3
  } hz_class_t;

  localparam int DEF_REG_ADDR_W        = 5;
  localparam int DEF_LOAD_USE_STALL    = 1;
  localparam int DEF_BRANCH_LOAD_STALL = 2;
  localparam int DEF_BRANCH_ALU_STALL  = 1;
  localparam int DEF_FLUSH_CYCLES      = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_classify.sv
// Combinational hazard classifier: register match between the ID sources and
// the EX destination, resolved to a single class by fixed priority.
module hazard_classify
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  id_valid,
  input  logic                  id_attempt_branch,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output hz_class_t             hz_class
);

  logic match;

  // Register match (x0 never creates a dependency), then class priority.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    hz_class = HZ_NONE;
    match    = id_valid && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (match) begin
      if (ex_mem_read && id_attempt_branch)       hz_class = HZ_BR_LOAD;
      else if (ex_mem_read)                       hz_class = HZ_LOAD_USE;
      else if (id_attempt_branch && ex_reg_write) hz_class = HZ_BR_ALU;
      else                                        hz_class = HZ_NONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: counts out multi-cycle stalls and flushes
// instead of re-detecting every cycle, and freezes while the EX unit is busy.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush counters;
// without it both perf ports are tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
  parameter int LOAD_USE_STALL    = DEF_LOAD_USE_STALL,
  parameter int BRANCH_LOAD_STALL = DEF_BRANCH_LOAD_STALL,
  parameter int BRANCH_ALU_STALL  = DEF_BRANCH_ALU_STALL,
  parameter int FLUSH_CYCLES      = DEF_FLUSH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_attempt_branch,
  input  logic                  id_branch_taken,
  input  logic                  id_predict_taken,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_busy,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output stall_cause_t          stall_cause,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flush_events
);

  localparam int MAX_LEN = max_int(max_int(LOAD_USE_STALL, BRANCH_LOAD_STALL),
                                   max_int(BRANCH_ALU_STALL, FLUSH_CYCLES));
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LU_LEN    = cnt_t'(LOAD_USE_STALL);
  localparam cnt_t BL_LEN    = cnt_t'(BRANCH_LOAD_STALL);
  localparam cnt_t BA_LEN    = cnt_t'(BRANCH_ALU_STALL);
  localparam cnt_t FLUSH_REM = cnt_t'(FLUSH_CYCLES - 1);
  localparam cnt_t CNT_ONE   = cnt_t'(1);

  state_t       state;
  cnt_t         cnt;
  stall_cause_t cause_q;

  hz_class_t    hz_class;
  logic         hz_hit;
  cnt_t         hz_len;
  stall_cause_t hz_cause;
  logic         mispredict;

  hazard_classify #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_classify (
    .id_valid          (id_valid),
    .id_attempt_branch (id_attempt_branch),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .hz_class          (hz_class)
  );

  // Map the detected class to its stall length and reported cause.
  always_comb begin
    hz_len   = '0;
    hz_cause = NONE;
    case (hz_class)
      HZ_BR_LOAD:  begin hz_len = BL_LEN; hz_cause = BRANCH;   end
      HZ_LOAD_USE: begin hz_len = LU_LEN; hz_cause = LOAD_USE; end
      HZ_BR_ALU:   begin hz_len = BA_LEN; hz_cause = BRANCH;   end
      default:     begin hz_len = '0;     hz_cause = NONE;     end
    endcase
    hz_hit     = (hz_class != HZ_NONE);
    mispredict = id_valid && id_attempt_branch &&
                 (id_branch_taken != id_predict_taken);
  end

  // Pipeline controls; a busy EX unit overrides everything and freezes the front end.
  always_comb begin
    stall       = 1'b0;
    bubble      = 1'b0;
    flush       = 1'b0;
    stall_cause = NONE;
    if (ex_busy) begin
      stall       = 1'b1;
      stall_cause = BUSY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hz_hit) begin
            stall       = 1'b1;
            bubble      = 1'b1;
            stall_cause = hz_cause;
          end else if (mispredict) begin
            flush  = 1'b1;
            bubble = 1'b1;
          end
        end
        ST_STALL: begin
          stall       = 1'b1;
          bubble      = 1'b1;
          stall_cause = cause_q;
        end
        ST_FLUSH: begin
          flush  = 1'b1;
          bubble = 1'b1;
        end
        default: begin
          stall       = 1'b0;
          bubble      = 1'b0;
        end
      endcase
    end
  end

  // Sequencer: enter STALL/FLUSH with the remaining-cycle count, hold while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cause_q <= NONE;
    end else if (!ex_busy) begin
      case (state)
        ST_IDLE: begin
          if (hz_hit) begin
            if (hz_len > CNT_ONE) begin
              cnt     <= hz_len - CNT_ONE;
              cause_q <= hz_cause;
              state   <= ST_STALL;
            end
          end else if (mispredict && (FLUSH_CYCLES > 1)) begin
            cnt   <= FLUSH_REM;
            state <= ST_FLUSH;
          end
        end
        ST_STALL: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= ST_IDLE;
            cause_q <= NONE;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          cause_q <= NONE;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic flush_start;

  // A flush event is counted only when it starts from IDLE, once per mispredict.
  always_comb begin
    flush_start = !ex_busy && (state == ST_IDLE) && !hz_hit && mispredict;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if (stall && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_start && (perf_flush_events != '1))
        perf_flush_events <= perf_flush_events + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with distinct stall lengths per class
// (load-use 1, branch-load 3, branch-ALU 2, flush 2).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         id_valid;
  logic         id_attempt_branch;
  logic         id_branch_taken;
  logic         id_predict_taken;
  logic [4:0]   id_rs1;
  logic [4:0]   id_rs2;
  logic         ex_reg_write;
  logic         ex_mem_read;
  logic [4:0]   ex_rd;
  logic         ex_busy;
  logic         stall;
  logic         bubble;
  logic         flush;
  stall_cause_t stall_cause;
  logic [31:0]  perf_stall_cycles;
  logic [31:0]  perf_flush_events;

  int errors = 0;
  int checks = 0;
  int exp_stall_cycles = 0;
  int exp_flush_events = 0;

  hazard_ctrl #(
    .REG_ADDR_W        (5),
    .LOAD_USE_STALL    (1),
    .BRANCH_LOAD_STALL (3),
    .BRANCH_ALU_STALL  (2),
    .FLUSH_CYCLES      (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_attempt_branch (id_attempt_branch),
    .id_branch_taken   (id_branch_taken),
    .id_predict_taken  (id_predict_taken),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .ex_reg_write      (ex_reg_write),
    .ex_mem_read       (ex_mem_read),
    .ex_rd             (ex_rd),
    .ex_busy           (ex_busy),
    .stall             (stall),
    .bubble            (bubble),
    .flush             (flush),
    .stall_cause       (stall_cause),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_events (perf_flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic br, input logic tk, input logic pr,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_attempt_branch = br; id_branch_taken = tk; id_predict_taken = pr;
    id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic set_ex(input logic wr, input logic mr, input logic [4:0] rd);
    ex_reg_write = wr; ex_mem_read = mr; ex_rd = rd;
  endtask

  task automatic chk_outs(input string tag, input logic es, input logic eb,
                          input logic ef, input stall_cause_t ec);
    check({tag, ".stall"},  32'(stall),  32'(es));
    check({tag, ".bubble"}, 32'(bubble), 32'(eb));
    check({tag, ".flush"},  32'(flush),  32'(ef));
    check({tag, ".cause"},  32'(stall_cause), 32'(ec));
  endtask

  // Check outputs mid-cycle, then advance one clock; the expected stall is
  // accumulated for the performance-counter model.
  task automatic cyc(input string tag, input logic es, input logic eb,
                     input logic ef, input stall_cause_t ec);
    @(negedge clk);
    chk_outs(tag, es, eb, ef, ec);
    @(posedge clk);
    #1;
    if (es) exp_stall_cycles++;
  endtask

  task automatic chk_perf(input string tag);
`ifdef HAZARD_PERF_EN
    check({tag, ".perf_stall"}, perf_stall_cycles, 32'(exp_stall_cycles));
    check({tag, ".perf_flush"}, perf_flush_events, 32'(exp_flush_events));
`else
    check({tag, ".perf_stall"}, perf_stall_cycles, 32'd0);
    check({tag, ".perf_flush"}, perf_flush_events, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    ex_busy = 1'b0;
    set_id(0, 0, 0, 0, 5'd0, 5'd0);
    set_ex(0, 0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, NONE);
    check("reset.perf_stall", perf_stall_cycles, 32'd0);
    check("reset.perf_flush", perf_flush_events, 32'd0);
    rst_n = 1'b1;
    cyc("idle", 0, 0, 0, NONE);

    // Load followed by dependent non-branch: one cycle, cause LOAD_USE.
    set_id(1, 0, 0, 0, 5'd3, 5'd5);
    set_ex(1, 1, 5'd5);
    cyc("lu0", 1, 1, 0, LOAD_USE);
    set_ex(0, 0, 5'd0);
    cyc("lu1", 0, 0, 0, NONE);

    // Load followed by dependent mispredicted branch: 3 stall cycles with the
    // mispredict ignored, then the resolved branch flushes for 2 cycles.
    set_id(1, 1, 1, 0, 5'd7, 5'd2);
    set_ex(1, 1, 5'd7);
    cyc("bl0", 1, 1, 0, BRANCH);
    set_ex(0, 0, 5'd0);
    cyc("bl1", 1, 1, 0, BRANCH);
    cyc("bl2", 1, 1, 0, BRANCH);
    exp_flush_events++;
    cyc("blf0", 0, 1, 1, NONE);
    set_id(0, 0, 0, 0, 5'd0, 5'd0);
    cyc("blf1", 0, 1, 1, NONE);
    cyc("bl_end", 0, 0, 0, NONE);

    // x0 never matches; invalid ID never matches; no-write ALU never matches.
    set_id(1, 0, 0, 0, 5'd0, 5'd0);
    set_ex(1, 1, 5'd0);
    cyc("x0", 0, 0, 0, NONE);
    set_id(0, 0, 0, 0, 5'd9, 5'd9);
    set_ex(1, 1, 5'd9);
    cyc("novalid", 0, 0, 0, NONE);
    set_id(1, 1, 0, 0, 5'd9, 5'd4);
    set_ex(0, 0, 5'd9);
    cyc("nowrite", 0, 0, 0, NONE);

    // Standalone mispredict (predicted taken, not taken); a hazard presented
    // during FLUSH is ignored.
    set_id(1, 1, 0, 1, 5'd1, 5'd2);
    set_ex(0, 0, 5'd0);
    exp_flush_events++;
    cyc("mp0", 0, 1, 1, NONE);
    set_id(1, 0, 0, 0, 5'd6, 5'd0);
    set_ex(1, 1, 5'd6);
    cyc("mp1", 0, 1, 1, NONE);
    set_id(0, 0, 0, 0, 5'd0, 5'd0);
    set_ex(0, 0, 5'd0);
    cyc("mp_end", 0, 0, 0, NONE);
    chk_perf("mid");

    // ALU write followed by dependent branch (2 cycles) with 4 busy cycles in
    // the middle: 6 stall cycles, no bubble while busy.
    set_id(1, 1, 1, 1, 5'd4, 5'd3);
    set_ex(1, 0, 5'd3);
    cyc("ba0", 1, 1, 0, BRANCH);
    set_ex(0, 0, 5'd0);
    ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("busy%0d", i), 1, 0, 0, BUSY);
    ex_busy = 1'b0;
    cyc("ba1", 1, 1, 0, BRANCH);
    // Back-to-back: load-use detected in the first IDLE cycle after STALL.
    set_id(1, 0, 0, 0, 5'd8, 5'd1);
    set_ex(1, 1, 5'd8);
    cyc("b2b", 1, 1, 0, LOAD_USE);

    // Hazard arriving during busy is deferred until busy drops.
    set_ex(1, 1, 5'd1);
    ex_busy = 1'b1;
    cyc("defer0", 1, 0, 0, BUSY);
    ex_busy = 1'b0;
    cyc("defer1", 1, 1, 0, LOAD_USE);
    set_id(0, 0, 0, 0, 5'd0, 5'd0);
    set_ex(0, 0, 5'd0);
    cyc("defer_end", 0, 0, 0, NONE);
    chk_perf("pre_rst");

    // Reset asserted in the first STALL cycle aborts immediately.
    set_id(1, 1, 0, 0, 5'd2, 5'd0);
    set_ex(1, 1, 5'd2);
    cyc("rs0", 1, 1, 0, BRANCH);
    set_ex(0, 0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("rst_mid", 0, 0, 0, NONE);
    exp_stall_cycles = 0;
    exp_flush_events = 0;
    check("rst_mid.perf_stall", perf_stall_cycles, 32'd0);
    check("rst_mid.perf_flush", perf_flush_events, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("post_rst0", 0, 0, 0, NONE);
    cyc("post_rst1", 0, 0, 0, NONE);
    set_id(1, 0, 0, 0, 5'd2, 5'd0);
    set_ex(1, 1, 5'd2);
    cyc("post_rst_lu", 1, 1, 0, LOAD_USE);
    set_id(0, 0, 0, 0, 5'd0, 5'd0);
    set_ex(0, 0, 5'd0);
    cyc("final", 0, 0, 0, NONE);
    chk_perf("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
